// File: rtl/frame_write_ctrl.sv
// Camera-side write sequencer for the frame buffer: qualifies frames on vsync,
// pairs RGB565 bytes into pixels, converts to 7-bit gray and drives BRAM port A.
module frame_write_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              config_done,
    input  logic              cam_href,
    input  logic              cam_vsync,
    input  logic [7:0]        cam_data,
    input  logic              mode_single,
    input  logic              capture_req,
    output logic              capture_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [6:0]        wr_data,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        frame_count
);

    localparam int X_W = $clog2(H_ACTIVE + 1);
    localparam int Y_W = $clog2(V_ACTIVE + 1);
    localparam logic [X_W-1:0]    X_LIM     = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    Y_LIM     = Y_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, HOLD} state_t;

    state_t            state;
    logic              href_q, href_qq, vsync_q, vsync_qq;
    logic [7:0]        data_q;
    logic [7:0]        hi_byte;
    logic              phase;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [Y_W-1:0]    y_next;
    logic [ADDR_W-1:0] line_base;
    logic [ADDR_W-1:0] addr_cnt;
    logic              href_rise, href_fall, vsync_rise, vsync_fall;
    logic              hi_load, pix_in_win, line_adv, snap_ok;

    function automatic logic [6:0] rgb565_to_gray7(input logic [7:0] hi, input logic [7:0] lo);
        logic [7:0] r_term, g_term, b_term, sum;
        r_term = {hi[7:3], 3'b000} >> 2;
        g_term = {hi[2:0], lo[7:5], 2'b00} >> 1;
        b_term = {lo[4:0], 3'b000} >> 2;
        sum    = r_term + g_term + b_term;
        return 7'(sum >> 1);
    endfunction

    assign href_rise  = href_q & ~href_qq;
    assign href_fall  = ~href_q & href_qq;
    assign vsync_rise = vsync_q & ~vsync_qq;
    assign vsync_fall = ~vsync_q & vsync_qq;
    assign hi_load    = (state == CAPTURE) && href_q && (href_rise || !phase);
    assign pix_in_win = (x < X_LIM) && (y < Y_LIM);
    assign line_adv   = href_fall && (y < Y_LIM);
    // A line ending in the same cycle as the frame must count toward the error compare.
    assign y_next     = line_adv ? y + Y_W'(1) : y;
    assign snap_ok    = capture_busy || capture_req;

    // Stage p0: input capture and edge history
    always_ff @(posedge pclk) begin
        if (reset) begin
            href_q   <= 1'b0;
            href_qq  <= 1'b0;
            vsync_q  <= 1'b0;
            vsync_qq <= 1'b0;
        end else begin
            href_q   <= cam_href;
            href_qq  <= href_q;
            vsync_q  <= cam_vsync;
            vsync_qq <= vsync_q;
        end
    end

    always_ff @(posedge pclk) begin
        data_q <= cam_data;
        if (hi_load)
            hi_byte <= data_q;
    end

    // Stage p1: frame sequencing and registered write port
    always_ff @(posedge pclk) begin
        if (reset) begin
            state        <= IDLE;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            frame_count  <= '0;
            capture_busy <= 1'b0;
            phase        <= 1'b0;
            x            <= '0;
            y            <= '0;
            line_base    <= '0;
            addr_cnt     <= '0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (!config_done) begin
                state        <= IDLE;
                capture_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: state <= ARMED;
                    ARMED: begin
                        if (mode_single && capture_req)
                            capture_busy <= 1'b1;
                        if (vsync_fall && (!mode_single || snap_ok)) begin
                            state     <= CAPTURE;
                            phase     <= 1'b0;
                            x         <= '0;
                            y         <= '0;
                            line_base <= '0;
                            addr_cnt  <= '0;
                        end
                    end
                    CAPTURE: begin
                        if (href_rise) begin
                            phase    <= 1'b1;
                            x        <= '0;
                            addr_cnt <= line_base;
                        end else if (href_q) begin
                            phase <= ~phase;
                            if (phase && pix_in_win) begin
                                wr_en    <= 1'b1;
                                wr_addr  <= addr_cnt;
                                wr_data  <= rgb565_to_gray7(hi_byte, data_q);
                                x        <= x + X_W'(1);
                                addr_cnt <= addr_cnt + ADDR_W'(1);
                            end
                        end
                        if (line_adv) begin
                            y         <= y_next;
                            line_base <= line_base + LINE_STEP;
                        end
                        if (vsync_rise) begin
                            frame_done   <= 1'b1;
                            frame_err    <= (y_next < Y_LIM);
                            frame_count  <= frame_count + 8'd1;
                            capture_busy <= 1'b0;
                            state        <= mode_single ? HOLD : ARMED;
                        end
                    end
                    HOLD: begin
                        if (capture_req) begin
                            state        <= ARMED;
                            capture_busy <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Directed bench for frame_write_ctrl with a 4x2 frame: checks addressing, gray
// conversion, line/frame boundaries, snapshot handshake and abort behaviour.
module tb_frame_write_ctrl;

    logic        pclk = 1'b0;
    logic        reset, config_done, cam_href, cam_vsync, mode_single, capture_req;
    logic [7:0]  cam_data;
    logic        capture_busy, wr_en, frame_done, frame_err;
    logic [18:0] wr_addr;
    logic [6:0]  wr_data;
    logic [7:0]  frame_count;

    int n_chk = 0;
    int n_fail = 0;
    int fd_cnt = 0;
    logic [31:0] wa_q[$];
    logic [6:0]  wd_q[$];
    logic [7:0]  lb[16];

    frame_write_ctrl #(.H_ACTIVE(4), .V_ACTIVE(2), .ADDR_W(19)) dut (
        .pclk(pclk), .reset(reset), .config_done(config_done),
        .cam_href(cam_href), .cam_vsync(cam_vsync), .cam_data(cam_data),
        .mode_single(mode_single), .capture_req(capture_req),
        .capture_busy(capture_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .frame_done(frame_done), .frame_err(frame_err),
        .frame_count(frame_count)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (wr_en) begin
            wa_q.push_back(32'(wr_addr));
            wd_q.push_back(wr_data);
        end
        if (frame_done)
            fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        fd_cnt = 0;
    endtask

    task automatic fill(input logic [7:0] a, input logic [7:0] b);
        for (int i = 0; i < 16; i++) lb[i] = (i % 2 == 0) ? a : b;
    endtask

    task automatic send_line(input int n, input bit vs_end);
        for (int i = 0; i < n; i++) begin
            cam_href = 1'b1;
            cam_data = lb[i];
            tick();
        end
        cam_href = 1'b0;
        cam_data = 8'h00;
        if (vs_end) cam_vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic frame_begin();
        clear_mon();
        cam_vsync = 1'b1;
        repeat (3) tick();
        cam_vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic frame_end();
        cam_vsync = 1'b1;
        repeat (6) tick();
    endtask

    task automatic white_frame(input int lines);
        frame_begin();
        fill(8'hFF, 8'hFF);
        for (int l = 0; l < lines; l++) send_line(8, 1'b0);
        frame_end();
    endtask

    task automatic chk_addrs(input string tag, input int n_exp);
        int n;
        chk({tag, "_nwr"}, wa_q.size(), n_exp);
        n = (wa_q.size() < n_exp) ? wa_q.size() : n_exp;
        for (int i = 0; i < n; i++) chk($sformatf("%s_addr%0d", tag, i), wa_q[i], i);
    endtask

    // Runs one frame whose first line is cut by either reset or a config_done drop.
    task automatic aborted_frame(input bit use_reset, input string tag);
        frame_begin();
        for (int i = 0; i < 4; i++) begin
            cam_href = 1'b1;
            cam_data = 8'hFF;
            tick();
        end
        if (use_reset) reset = 1'b1; else config_done = 1'b0;
        tick();
        chk({tag, "_wren_drop"}, wr_en, 0);
        tick();
        reset = 1'b0;
        config_done = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        cam_href = 1'b0;
        repeat (4) tick();
        fill(8'hFF, 8'hFF);
        send_line(8, 1'b0);
        frame_end();
        chk({tag, "_nwr"}, wa_q.size(), 1);
        chk({tag, "_fd"}, fd_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; config_done = 1'b0; cam_href = 1'b0; cam_vsync = 1'b1;
        cam_data = 8'h00; mode_single = 1'b0; capture_req = 1'b0;
        repeat (3) tick();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_busy", capture_busy, 0);
        reset = 1'b0;
        config_done = 1'b1;
        repeat (3) tick();

        // White pixels: r=62, g=126, b=62 -> gray8 250 -> 7'h7D
        white_frame(2);
        chk_addrs("f1", 8);
        for (int i = 0; i < wd_q.size(); i++) chk($sformatf("f1_data%0d", i), wd_q[i], 7'h7D);
        chk("f1_fd", fd_cnt, 1);
        chk("f1_err", frame_err, 0);
        chk("f1_count", frame_count, 1);

        frame_begin();
        lb[0] = 8'hF8; lb[1] = 8'h00; lb[2] = 8'h07; lb[3] = 8'hE0;
        lb[4] = 8'h00; lb[5] = 8'h1F; lb[6] = 8'h00; lb[7] = 8'h00;
        send_line(8, 1'b0);
        fill(8'h00, 8'h00);
        send_line(8, 1'b0);
        frame_end();
        chk("col_nwr", wd_q.size(), 8);
        if (wd_q.size() >= 4) begin
            chk("col_red", wd_q[0], 7'h1F);
            chk("col_green", wd_q[1], 7'h3F);
            chk("col_blue", wd_q[2], 7'h1F);
            chk("col_black", wd_q[3], 7'h00);
        end
        chk("col_count", frame_count, 2);

        frame_begin();
        fill(8'hFF, 8'hFF);
        send_line(11, 1'b0);
        fill(8'hF8, 8'h00);
        send_line(8, 1'b0);
        frame_end();
        chk_addrs("odd", 8);
        if (wd_q.size() >= 5) begin
            chk("odd_l1_last", wd_q[3], 7'h7D);
            chk("odd_l2_first", wd_q[4], 7'h1F);
        end
        chk("odd_err", frame_err, 0);

        white_frame(1);
        chk_addrs("short", 4);
        chk("short_fd", fd_cnt, 1);
        chk("short_err", frame_err, 1);
        chk("short_count", frame_count, 4);

        white_frame(2);
        chk_addrs("after_short", 8);
        chk("after_short_err", frame_err, 0);

        frame_begin();
        fill(8'hFF, 8'hFF);
        send_line(8, 1'b0);
        send_line(8, 1'b1);
        repeat (4) tick();
        chk("simul_fd", fd_cnt, 1);
        chk("simul_err", frame_err, 0);
        chk("simul_nwr", wa_q.size(), 8);
        chk("simul_count", frame_count, 6);

        mode_single = 1'b1;
        for (int f = 0; f < 2; f++) begin
            white_frame(2);
            chk($sformatf("snap_noreq%0d_nwr", f), wa_q.size(), 0);
            chk($sformatf("snap_noreq%0d_fd", f), fd_cnt, 0);
        end
        chk("snap_idle_busy", capture_busy, 0);
        capture_req = 1'b1;
        tick();
        capture_req = 1'b0;
        tick();
        chk("snap_busy_set", capture_busy, 1);
        white_frame(2);
        chk_addrs("snap", 8);
        chk("snap_fd", fd_cnt, 1);
        chk("snap_busy_clr", capture_busy, 0);
        chk("snap_count", frame_count, 7);
        white_frame(2);
        chk("hold_nwr", wa_q.size(), 0);
        chk("hold_fd", fd_cnt, 0);

        mode_single = 1'b0;
        config_done = 1'b0;
        repeat (2) tick();
        config_done = 1'b1;
        repeat (2) tick();
        aborted_frame(1'b0, "cfgdrop");
        chk("cfgdrop_count", frame_count, 7);
        white_frame(2);
        chk_addrs("cfg_resume", 8);
        chk("cfg_resume_count", frame_count, 8);

        aborted_frame(1'b1, "rstmid");
        chk("rstmid_count", frame_count, 0);
        white_frame(2);
        chk_addrs("rst_resume", 8);
        chk("rst_resume_count", frame_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
